// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues single outstanding word requests to
// instruction memory and presents one instruction at a time to decode. Optional: IFU_ALIGN_CHECK_EN.
module ifu_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h80000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    localparam logic [XLEN-1:0] NOP     = XLEN'(32'h00000013);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc_r, pc_nxt;
    logic [XLEN-1:0] inst_r, inst_nxt;
    logic [XLEN-1:0] inst_pc_r, inst_pc_nxt;
    logic            drop, drop_nxt;
    logic            misaligned;
    logic            req_fire;

    function automatic logic [XLEN-1:0] redirect_target(input logic [XLEN-1:0] pc);
`ifdef IFU_ALIGN_CHECK_EN
        return pc;
`else
        return pc & ~XLEN'(3);
`endif
    endfunction

`ifdef IFU_ALIGN_CHECK_EN
    assign misaligned = |pc_r[1:0];
`else
    assign misaligned = 1'b0;
`endif

    assign imem_req_valid = (state == REQ) && !misaligned;
    assign imem_req_addr  = pc_r;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign inst_valid     = (state == HOLD);
    assign inst           = inst_r;
    assign inst_pc        = inst_pc_r;

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc_r;
        drop_nxt    = drop;
        inst_nxt    = inst_r;
        inst_pc_nxt = inst_pc_r;
        case (state)
            IDLE: begin
                state_nxt = REQ;
                if (redirect_valid) pc_nxt = redirect_target(redirect_pc);
            end
            REQ: begin
                if (misaligned) begin
                    // A misaligned PC never reaches memory; it is reported as a faulting nop.
                    if (redirect_valid) begin
                        pc_nxt = redirect_target(redirect_pc);
                    end else begin
                        state_nxt   = HOLD;
                        inst_nxt    = NOP;
                        inst_pc_nxt = pc_r;
                    end
                end else if (req_fire) begin
                    state_nxt = WAIT;
                    if (redirect_valid) begin
                        drop_nxt = 1'b1;
                        pc_nxt   = redirect_target(redirect_pc);
                    end
                end else if (redirect_valid) begin
                    pc_nxt = redirect_target(redirect_pc);
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (drop || redirect_valid) begin
                        drop_nxt  = 1'b0;
                        state_nxt = REQ;
                        if (redirect_valid) pc_nxt = redirect_target(redirect_pc);
                    end else begin
                        inst_nxt    = imem_rsp_data;
                        inst_pc_nxt = pc_r;
                        state_nxt   = HOLD;
                    end
                end else if (redirect_valid) begin
                    // Response still in flight: remember to throw it away when it lands.
                    drop_nxt = 1'b1;
                    pc_nxt   = redirect_target(redirect_pc);
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_target(redirect_pc);
                    state_nxt = REQ;
                end else if (inst_ready) begin
                    pc_nxt    = pc_r + PC_STEP;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc_r      <= RESET_PC;
            drop      <= 1'b0;
            inst_r    <= '0;
            inst_pc_r <= '0;
        end else begin
            state     <= state_nxt;
            pc_r      <= pc_nxt;
            drop      <= drop_nxt;
            inst_r    <= inst_nxt;
            inst_pc_r <= inst_pc_nxt;
        end
    end

`ifdef IFU_ALIGN_CHECK_EN
    logic fault_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_r <= 1'b0;
        end else if (state == REQ && misaligned && !redirect_valid) begin
            fault_r <= 1'b1;
        end else if (state == HOLD && (redirect_valid || inst_ready)) begin
            fault_r <= 1'b0;
        end
    end

    assign inst_fault = fault_r;
`else
    assign inst_fault = 1'b0;
`endif

endmodule
